// File: rtl/request_queue_bank.sv
// Bank of per-queue request FIFOs feeding a single output slot.
// A scheduler grant pops one queue into the slot; downstream drains it.
module request_queue_bank #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int QUEUE_DEPTH      = 8,
  parameter int DATA_WIDTH       = 64
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUMBER_OF_QUEUES-1:0]                  in_valid,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]  in_data,
  output logic [NUMBER_OF_QUEUES-1:0]                  in_ready,
  output logic [NUMBER_OF_QUEUES-1:0]                  full,
  output logic [NUMBER_OF_QUEUES-1:0]                  empty,
  output logic [NUMBER_OF_QUEUES-1:0]                  lastElem,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]          id,
  input  logic                                         valid_and_ready,
  output logic                                         ready,
  output logic                                         out_valid,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]          out_id,
  input  logic                                         out_ready,
  output logic                                         consumed,
  output logic                                         grant_error
);

  localparam int N  = NUMBER_OF_QUEUES;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                  state_q;
  logic [N-1:0][PW-1:0]    rd_q, rd_d;
  logic [N-1:0][PW-1:0]    wr_q, wr_d;
  logic [N-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [N][QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [IW-1:0]           out_id_q;
  logic                    consumed_q;
  logic                    grant_error_q;
  logic [N-1:0]            push, pop;
  logic                    grant_ok, grant_bad;

  // Status flags come from registered counts only
  always_comb begin
    for (int q = 0; q < N; q++) begin
      full[q]     = (cnt_q[q] == CW'(QUEUE_DEPTH));
      empty[q]    = (cnt_q[q] == '0);
      lastElem[q] = (cnt_q[q] == CW'(1));
      in_ready[q] = ~full[q];
    end
  end

  assign grant_ok  = (state_q == IDLE) && valid_and_ready && !empty[id];
  assign grant_bad = (state_q == IDLE) && valid_and_ready && empty[id];

  // Per-queue push/pop decode and pointer/count next state
  always_comb begin
    push = '0;
    pop  = '0;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    for (int q = 0; q < N; q++) begin
      push[q] = in_valid[q] && !full[q];
      pop[q]  = grant_ok && (id == IW'(q));
      if (push[q]) wr_d[q] = wr_q[q] + PW'(1);
      if (pop[q])  rd_d[q] = rd_q[q] + PW'(1);
      unique case ({push[q], pop[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CW'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CW'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage, left uninitialised by reset
  always_ff @(posedge clock) begin
    for (int q = 0; q < N; q++) begin
      if (push[q]) mem_q[q][wr_q[q]] <= in_data[q];
    end
  end

  // Output slot FSM with registered payload, pulse and error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      out_data_q    <= '0;
      out_id_q      <= '0;
      consumed_q    <= 1'b0;
      grant_error_q <= 1'b0;
    end else begin
      consumed_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_ok) begin
            out_data_q <= mem_q[id][rd_q[id]];
            out_id_q   <= id;
            state_q    <= HOLD;
          end
          if (grant_bad) grant_error_q <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= IDLE;
            consumed_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign out_data    = out_data_q;
  assign out_id      = out_id_q;
  assign consumed    = consumed_q;
  assign grant_error = grant_error_q;

endmodule

// File: tb/tb_request_queue_bank.sv
// Directed bench for request_queue_bank with default parameters.
// Immediate assertions at each check point, one summary line at the end.
module tb_request_queue_bank;

  logic             clock;
  logic             reset;
  logic [3:0]       in_valid;
  logic [3:0][63:0] in_data;
  logic [3:0]       in_ready;
  logic [3:0]       full;
  logic [3:0]       empty;
  logic [3:0]       lastElem;
  logic [1:0]       id;
  logic             valid_and_ready;
  logic             ready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic [1:0]       out_id;
  logic             out_ready;
  logic             consumed;
  logic             grant_error;

  int compared = 0;
  int mismatched = 0;

  request_queue_bank dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .full(full),
    .empty(empty),
    .lastElem(lastElem),
    .id(id),
    .valid_and_ready(valid_and_ready),
    .ready(ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .out_ready(out_ready),
    .consumed(consumed),
    .grant_error(grant_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_q1 [3];
    int k;
    int pulses;
    int last_pulse;
    int min_gap;

    reset = 1'b1;
    in_valid = '0;
    in_data = '0;
    id = '0;
    valid_and_ready = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_last", 64'(lastElem), 64'h0);
    chk("rst_inrdy", 64'(in_ready), 64'hF);
    chk("rst_ready", 64'(ready), 64'h1);
    chk("rst_ovalid", 64'(out_valid), 64'h0);
    chk("rst_odata", out_data, 64'h0);
    chk("rst_oid", 64'(out_id), 64'h0);
    chk("rst_cons", 64'(consumed), 64'h0);
    chk("rst_gerr", 64'(grant_error), 64'h0);

    // single push / grant / consume on q2
    in_valid = 4'b0100;
    in_data[2] = 64'hA1;
    tick();
    in_valid = '0;
    chk("q2_empty", 64'(empty), 64'hB);
    chk("q2_last", 64'(lastElem), 64'h4);
    id = 2'd2;
    valid_and_ready = 1'b1;
    tick();
    valid_and_ready = 1'b0;
    chk("q2_ovalid", 64'(out_valid), 64'h1);
    chk("q2_odata", out_data, 64'hA1);
    chk("q2_oid", 64'(out_id), 64'h2);
    chk("q2_ready", 64'(ready), 64'h0);
    chk("q2_empty2", 64'(empty), 64'hF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("q2_cons", 64'(consumed), 64'h1);
    chk("q2_ovalid0", 64'(out_valid), 64'h0);
    tick();
    chk("q2_cons_pulse", 64'(consumed), 64'h0);

    // fill q0 to full
    for (int i = 0; i < 8; i++) begin
      in_valid = 4'b0001;
      in_data[0] = 64'h100 + 64'(i);
      tick();
    end
    chk("q0_full", 64'(full), 64'h1);
    chk("q0_inrdy", 64'(in_ready), 64'hE);
    in_data[0] = 64'hDEAD;
    tick();
    in_valid = '0;
    chk("q0_full_drop", 64'(full), 64'h1);

    // pop while full with a push: push dropped, count 7
    id = 2'd0;
    valid_and_ready = 1'b1;
    in_valid = 4'b0001;
    in_data[0] = 64'hBEEF;
    tick();
    valid_and_ready = 1'b0;
    in_valid = '0;
    chk("q0_pop_full", out_data, 64'h100);
    chk("q0_notfull", 64'(full), 64'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("q0_cons_a", 64'(consumed), 64'h1);

    // simultaneous push and pop at count 7
    valid_and_ready = 1'b1;
    in_valid = 4'b0001;
    in_data[0] = 64'h108;
    tick();
    valid_and_ready = 1'b0;
    in_valid = '0;
    chk("q0_pp_data", out_data, 64'h101);
    chk("q0_pp_full", 64'(full), 64'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    in_data[0] = 64'h109;
    tick();
    in_valid = '0;
    chk("q0_refull", 64'(full), 64'h1);

    // drain across pointer wrap
    for (int i = 0; i < 8; i++) begin
      valid_and_ready = 1'b1;
      tick();
      valid_and_ready = 1'b0;
      chk($sformatf("q0_drain%0d", i), out_data, 64'h102 + 64'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("q0_drained", 64'(empty), 64'hF);

    // grant to empty queue
    id = 2'd1;
    valid_and_ready = 1'b1;
    tick();
    valid_and_ready = 1'b0;
    chk("gerr_ovalid", 64'(out_valid), 64'h0);
    chk("gerr_set", 64'(grant_error), 64'h1);
    tick();
    tick();
    chk("gerr_sticky", 64'(grant_error), 64'h1);
    chk("gerr_ready", 64'(ready), 64'h1);

    // stall in HOLD with grants ignored
    in_valid = 4'b1000;
    in_data[3] = 64'h31;
    tick();
    in_data[3] = 64'h32;
    tick();
    in_valid = '0;
    id = 2'd3;
    valid_and_ready = 1'b1;
    tick();
    chk("hold_data0", out_data, 64'h31);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_data%0d", i + 1), out_data, 64'h31);
      chk($sformatf("hold_rdy%0d", i + 1), 64'(ready), 64'h0);
      chk($sformatf("hold_cnt%0d", i + 1), 64'(lastElem[3]), 64'h1);
    end
    valid_and_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_cons", 64'(consumed), 64'h1);

    // independent pushes, then back-to-back grants
    in_valid = 4'b0110;
    in_data[1] = 64'h11;
    in_data[2] = 64'h21;
    tick();
    in_valid = 4'b0010;
    in_data[1] = 64'h12;
    tick();
    in_data[1] = 64'h13;
    tick();
    in_valid = '0;
    chk("multi_empty", 64'(empty), 64'h1);
    chk("multi_last", 64'(lastElem), 64'hC);
    exp_q1[0] = 64'h11;
    exp_q1[1] = 64'h12;
    exp_q1[2] = 64'h13;
    k = 0;
    pulses = 0;
    last_pulse = -100;
    min_gap = 100;
    id = 2'd1;
    valid_and_ready = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid && k < 3) begin
        chk($sformatf("b2b_data%0d", k), out_data, exp_q1[k]);
        k++;
      end
      if (consumed) begin
        if (c - last_pulse < min_gap) min_gap = c - last_pulse;
        last_pulse = c;
        pulses++;
      end
    end
    valid_and_ready = 1'b0;
    out_ready = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_gap_ok", 64'(min_gap >= 2), 64'h1);
    chk("b2b_empty", 64'(empty[1]), 64'h1);

    // reset while in HOLD, with a completion pending
    id = 2'd2;
    valid_and_ready = 1'b1;
    tick();
    valid_and_ready = 1'b0;
    chk("rh_ovalid", 64'(out_valid), 64'h1);
    chk("rh_odata", out_data, 64'h21);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    chk("rh_ovalid0", 64'(out_valid), 64'h0);
    chk("rh_cons", 64'(consumed), 64'h0);
    chk("rh_empty", 64'(empty), 64'hF);
    chk("rh_gerr", 64'(grant_error), 64'h0);
    chk("rh_ready", 64'(ready), 64'h1);
    tick();
    chk("rh_cons2", 64'(consumed), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
